// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and decode helpers for the iterative RV32M multiply/divide unit.
//   muldiv_op_e    - funct3 encodings of the M-extension OP group
//   muldiv_state_e - control FSM states
//   helpers        - operation class and operand signedness decode
package muldiv_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_e;

    function automatic logic is_div(muldiv_op_e op);
        return op inside {OpDiv, OpDivu, OpRem, OpRemu};
    endfunction

    function automatic logic is_rem(muldiv_op_e op);
        return op inside {OpRem, OpRemu};
    endfunction

    function automatic logic op_a_signed(muldiv_op_e op);
        return op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    function automatic logic op_b_signed(muldiv_op_e op);
        return op inside {OpMulh, OpDiv, OpRem};
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negation.
// Used to turn signed operands into magnitudes and to restore the sign of the final result.
//   value  in  Width  input value
//   negate in  1      negate the value when high
//   result out Width  value or its two's-complement negation
module muldiv_sign_fix #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] value,
    input  logic             negate,
    output logic [Width-1:0] result
);

    assign result = negate ? (~value + Width'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (one bit per cycle, XLEN iterations).
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake; funct3, op_a, op_b, tag_in sampled on accept
//   flush               abort any in-flight or held operation
//   out_valid/out_ready result handshake; result, tag_out held stable while waiting
//   busy                operation in flight (CALC or DONE), used to stall the pipeline
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(XLEN + 1);
    localparam logic [CntW-1:0] LastIter = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN - 1){1'b0}}};

    muldiv_state_e      state_q, state_d;
    muldiv_op_e         op_q, op_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [XLEN-1:0]    b_q, b_d;
    logic [2*XLEN-1:0]  acc_q, acc_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [XLEN-1:0]    result_q, result_d;

    // Request decode and operand conditioning
    muldiv_op_e      op_in;
    logic            neg_a_in, neg_b_in, div_zero, div_ovf, fast_path;
    logic [XLEN-1:0] mag_a, mag_b, fast_result;

    assign op_in    = muldiv_op_e'(funct3);
    assign neg_a_in = op_a_signed(op_in) && op_a[XLEN-1];
    assign neg_b_in = op_b_signed(op_in) && op_b[XLEN-1];
    assign div_zero = is_div(op_in) && (op_b == '0);
    assign div_ovf  = (op_in inside {OpDiv, OpRem}) && (op_a == MinNeg) && (op_b == '1);
    assign fast_path = div_zero || div_ovf;

    always_comb begin
        fast_result = '0;
        if (div_zero) begin
            fast_result = is_rem(op_in) ? op_a : '1;
        end else if (div_ovf) begin
            fast_result = is_rem(op_in) ? '0 : op_a;
        end
    end

    muldiv_sign_fix #(.Width(XLEN)) u_fix_a (
        .value  (op_a),
        .negate (neg_a_in),
        .result (mag_a)
    );

    muldiv_sign_fix #(.Width(XLEN)) u_fix_b (
        .value  (op_b),
        .negate (neg_b_in),
        .result (mag_b)
    );

    // One iteration step. Multiply: multiplier sits in the low half and is shifted out while
    // the partial product builds up in the high half. Divide: {remainder, quotient} shift left.
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_next, div_next, step_acc;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    assign div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign step_acc  = is_div(op_q) ? div_next : mul_next;

    // Sign restoration over the full product so the high half sees the borrow from the low half
    logic [2*XLEN-1:0] fix_in, fix_out;
    logic              fix_neg;
    logic [XLEN-1:0]   final_result;

    always_comb begin
        fix_in = step_acc;
        if (is_div(op_q)) begin
            fix_in = {{XLEN{1'b0}}, is_rem(op_q) ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0]};
        end
    end

    // Remainder follows the dividend's sign; quotient and product follow the sign product
    assign fix_neg = is_rem(op_q) ? sign_a_q : (sign_a_q ^ sign_b_q);

    muldiv_sign_fix #(.Width(2 * XLEN)) u_fix_res (
        .value  (fix_in),
        .negate (fix_neg),
        .result (fix_out)
    );

    assign final_result = (is_div(op_q) || op_q == OpMul) ? fix_out[XLEN-1:0]
                                                          : fix_out[2*XLEN-1:XLEN];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OpMul;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
            tag_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            tag_q    <= tag_d;
            result_q <= result_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (in_valid) state_d = fast_path ? DONE : CALC;
                CALC:    if (cnt_q == LastIter) state_d = DONE;
                DONE:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next state
    always_comb begin
        op_d     = op_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_d      = b_q;
        acc_d    = acc_q;
        tag_d    = tag_q;
        result_d = result_q;
        if (flush) begin
            cnt_d = '0;
        end else if (state_q == IDLE && in_valid) begin
            op_d     = op_in;
            cnt_d    = '0;
            sign_a_d = neg_a_in;
            sign_b_d = neg_b_in;
            b_d      = mag_b;
            acc_d    = {{XLEN{1'b0}}, mag_a};
            tag_d    = tag_in;
            if (fast_path) begin
                result_d = fast_result;
            end
        end else if (state_q == CALC) begin
            acc_d = step_acc;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastIter) begin
                result_d = final_result;
            end
        end
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == CALC) || (state_q == DONE);
        result    = result_q;
        tag_out   = tag_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (XLEN=32). Expected results are queued on
// request and compared when the unit hands a result out.
module tb_muldiv_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  op_a, op_b, result;
    logic [TAG_W-1:0] tag_in, tag_out;

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tag;
        int               lat;
        int               acc_cyc;
    } exp_t;

    typedef struct {
        logic [2:0]      f;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] r;
        int              lat;
    } vec_t;

    exp_t sb_q[$];
    exp_t cur;
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   seen_valid = 1'b0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .tag_in    (tag_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .tag_out   (tag_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Result monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
            end else begin
                if (!seen_valid) begin
                    check_eq("latency", 64'(cyc - sb_q[0].acc_cyc + 1), 64'(sb_q[0].lat));
                    seen_valid = 1'b1;
                end
                if (out_ready && !flush) begin
                    cur = sb_q.pop_front();
                    check_eq("result", {32'd0, result}, {32'd0, cur.res});
                    check_eq("tag_out", {59'd0, tag_out}, {59'd0, cur.tag});
                    seen_valid = 1'b0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TAG_W-1:0] t, input logic [XLEN-1:0] exp_res,
                         input int lat, input bit push);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) check_eq("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        funct3   = f;
        op_a     = a;
        op_b     = b;
        tag_in   = t;
        in_valid = 1'b1;
        if (push) sb_q.push_back('{exp_res, t, lat, cyc + 1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        funct3   = 3'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        tag_in   = TAG_W'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_eq("drain_empty", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        seen_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        check_eq({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        funct3    = '0;
        op_a      = '0;
        op_b      = '0;
        tag_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        check_eq("reset_result", {32'd0, result}, 64'd0);
        check_eq("reset_tag_out", {59'd0, tag_out}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        vecs.push_back('{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
        vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33});
        vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33});
        vecs.push_back('{3'b101, 32'd100, 32'd7, 32'd14, 33});
        vecs.push_back('{3'b111, 32'd100, 32'd7, 32'd2, 33});
        vecs.push_back('{3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
        vecs.push_back('{3'b111, 32'd5, 32'd0, 32'd5, 1});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
        vecs.push_back('{3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1});

        // Back-to-back stream, out_ready held high
        foreach (vecs[i]) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b, TAG_W'(i + 1), vecs[i].r, vecs[i].lat, 1'b1);
        end
        drain();

        // Stall in DONE: result and tag must hold while out_ready is low
        out_ready = 1'b0;
        issue(3'b101, 32'd100, 32'd7, 5'd9, 32'd14, 33, 1'b1);
        begin
            int guard = 0;
            while (!out_valid && guard < 100) begin
                @(posedge clk);
                #1;
                guard++;
            end
        end
        check_eq("stall_out_valid", {63'd0, out_valid}, 64'd1);
        repeat (5) begin
            check_eq("stall_result", {32'd0, result}, 64'd14);
            check_eq("stall_tag_out", {59'd0, tag_out}, 64'd9);
            check_eq("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check_eq("stall_busy", {63'd0, busy}, 64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("post_hs_out_valid", {63'd0, out_valid}, 64'd0);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE, 33, 1'b1);
        check_eq("next_accept_busy", {63'd0, busy}, 64'd1);
        drain();

        // Flush at iteration 10 of CALC
        issue(3'b000, 32'd5, 32'd6, 5'd11, 32'd30, 33, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check_eq("pre_flush_busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_idle("flush");
        repeat (40) @(posedge clk);
        #1;
        issue(3'b000, 32'd3, 32'd4, 5'd12, 32'd12, 33, 1'b1);
        drain();

        // Same with reset mid-operation
        issue(3'b001, 32'h1234_5678, 32'h8765_4321, 5'd13, 32'd0, 33, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("rst_mid");
        repeat (40) @(posedge clk);
        #1;
        issue(3'b000, 32'd3, 32'd4, 5'd14, 32'd12, 33, 1'b1);
        drain();

        // flush together with in_valid: request must be dropped
        funct3   = 3'b000;
        op_a     = 32'd2;
        op_b     = 32'd2;
        tag_in   = 5'd15;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check_idle("flush_in_valid");
        repeat (40) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
